// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for elastic pipeline stage registers: state encoding and the
// canonical NOP payload used by the decode/execute boundary wrapper.
package pipe_stage_reg_pkg;

  // Encoding doubles as the entry count reported on occ_o.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic [4:0]  NopRegAddr = 5'b00000;
  localparam logic [31:0] NopInst    = 32'h0000_0000;
  localparam logic [7:0]  NopAluOp   = 8'h00;
  localparam logic [2:0]  NopAluSel  = 3'b000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } id_ex_payload_t;

  localparam int unsigned IdExDw = $bits(id_ex_payload_t);

  localparam id_ex_payload_t IdExNop = '{
    pc:     ZeroWord,
    inst:   NopInst,
    aluop:  NopAluOp,
    alusel: NopAluSel,
    reg1:   ZeroWord,
    reg2:   ZeroWord,
    wd:     NopRegAddr,
    wreg:   1'b0
  };

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with optional skid entry. Empty slots hold
// NOP_VAL so downstream always sees a harmless payload.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter logic [DW-1:0] NOP_VAL = '0,
  parameter bit            SKID    = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          up_valid_i,
  output logic          up_ready_o,
  input  logic [DW-1:0] up_data_i,
  output logic          dn_valid_o,
  input  logic          dn_ready_i,
  output logic [DW-1:0] dn_data_o,
  output logic [1:0]    occ_o
);

  pipe_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q;
  logic          up_fire, dn_fire;

  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = dn_valid_o & dn_ready_i;
  assign dn_valid_o = (state_q != ST_EMPTY);
  assign dn_data_o  = main_q;
  assign occ_o      = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            state_d = ST_BUSY;
            main_d  = up_data_i;
          end
        end
        ST_BUSY: begin
          if (up_fire && dn_fire) begin
            main_d = up_data_i;
          end else if (up_fire) begin
            // Only reachable with a skid entry; without it ready implies dn_fire here.
            state_d = ST_FULL;
          end else if (dn_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        ST_FULL: begin
          if (dn_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  if (SKID) begin : g_skid
    logic [DW-1:0] skid_r;
    logic          ready_r;

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        skid_r <= NOP_VAL;
      end else if (state_q == ST_BUSY && up_fire && !dn_fire) begin
        skid_r <= up_data_i;
      end else if (state_q == ST_FULL && dn_fire) begin
        skid_r <= NOP_VAL;
      end
    end

    // Ready is registered from the next state so upstream sees no combinational path.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ready_r <= 1'b1;
      end else begin
        ready_r <= (state_d != ST_FULL);
      end
    end

    assign skid_q     = skid_r;
    assign up_ready_o = ready_r;
  end else begin : g_no_skid
    assign skid_q     = NOP_VAL;
    assign up_ready_o = ~dn_valid_o | dn_ready_i;
  end

endmodule
